mdu_sequencer: RTL

//  Multi-cycle multiply/divide sequencer for the E stage; owns the HI/LO registers.

---
 rtl/mdu_sequencer.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//
// Multi-cycle multiply/divide sequencer for the E stage. It owns the
// architectural HI/LO registers. A MULT/MULTU/DIV/DIVU result is computed
// combinationally when the op is accepted and parked in a shadow pair. A
// down-counter then holds the unit busy for the configured latency before the
// shadow pair is committed to HI/LO. MTHI/MTLO write HI/LO directly with
// single-cycle latency.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (legal 1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (legal 1..15)
//
// Ports
//   clk       in   1   clock, all state updates on the rising edge
//   reset     in   1   synchronous, active-low reset
//   start     in   1   op valid in E this cycle
//   op        in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 NONE
//   a         in   32  rs operand (forwarded)
//   b         in   32  rt operand (forwarded)
//   cancel    in   1   abort the in-flight op (only with MDU_CANCEL_EN)
//   busy      out  1   registered: MUL/DIV in flight
//   stall_md  out  1   combinational: busy | (start & op is MULT..DIVU)
//   hi        out  32  HI register
//   lo        out  32  LO register
//
// Build option
//   MDU_CANCEL_EN  when defined, cancel aborts an in-flight op (no commit) and
//                  suppresses any start/MTHI/MTLO presented in the same cycle.
//                  When undefined, cancel is ignored.
// -----------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Op encoding
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;

  // The counter is loaded with N-1 on acceptance and the commit happens on the
  // edge where it is already zero, giving exactly N busy cycles.
  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Cancel qualification
  // ---------------------------------------------------------------------------
  logic cancel_act;
`ifdef MDU_CANCEL_EN
  assign cancel_act = cancel;
`else
  assign cancel_act = 1'b0;
  // cancel is a port in every build; it simply has no effect here.
  logic unused_cancel;
  assign unused_cancel = cancel;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d;
  logic [31:0] sh_lo_q, sh_lo_d;
  logic        sh_wr_q, sh_wr_d;   // 0 for a divide by zero: commit leaves HI/LO alone

  // ---------------------------------------------------------------------------
  // Multiply: both products are formed at 64 bits. The low 64 bits of a 64x64
  // product of sign-extended operands equal the signed 32x32 product.
  // ---------------------------------------------------------------------------
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign a_zx   = {32'd0, a};
  assign b_zx   = {32'd0, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // ---------------------------------------------------------------------------
  // Divide. The signed path works on magnitudes so that 0x80000000 / -1 has a
  // well-defined result (quotient 0x80000000, remainder 0) instead of relying
  // on native signed-division overflow behaviour. Quotient sign is the XOR of
  // the operand signs; remainder sign follows the dividend. A zero divisor is
  // replaced by 1 only to keep the divider well-defined; that result is never
  // committed.
  // ---------------------------------------------------------------------------
  logic        b_zero;
  logic [31:0] a_mag, b_mag, b_div_s, b_div_u;
  logic [31:0] qs_mag, rs_mag;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign b_zero  = (b == 32'd0);
  assign a_mag   = a[31] ? (~a + 32'd1) : a;
  assign b_mag   = b[31] ? (~b + 32'd1) : b;
  assign b_div_s = b_zero ? 32'd1 : b_mag;
  assign b_div_u = b_zero ? 32'd1 : b;

  assign qs_mag  = a_mag / b_div_s;
  assign rs_mag  = a_mag % b_div_s;
  assign q_s     = (a[31] ^ b[31]) ? (~qs_mag + 32'd1) : qs_mag;
  assign r_s     = a[31] ? (~rs_mag + 32'd1) : rs_mag;

  assign q_u     = a / b_div_u;
  assign r_u     = a % b_div_u;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !cancel_act) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {sh_hi_d, sh_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
              sh_wr_d            = 1'b1;
              cnt_d              = MULT_LOAD;
              state_d            = ST_MUL;
            end
            OP_DIV, OP_DIVU: begin
              sh_hi_d = (op == OP_DIV) ? r_s : r_u;
              sh_lo_d = (op == OP_DIV) ? q_s : q_u;
              sh_wr_d = !b_zero;
              cnt_d   = DIV_LOAD;
              state_d = ST_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;  // NONE and reserved encoding: no effect
          endcase
        end
      end

      ST_MUL, ST_DIV: begin
        // A new start while busy is ignored: the hazard unit must hold it off.
        if (cancel_act) begin
          // Cancel beats the commit even when the counter has reached zero.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          if (sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      sh_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. stall_md depends only on start/op/busy so that operand forwarding
  // (a/b) never sits on the hazard-unit timing path.
  // ---------------------------------------------------------------------------
  assign busy     = busy_q;
  assign stall_md = busy_q | (start & (op >= OP_MULT) & (op <= OP_DIVU));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
